// File: rtl/md5_uart_pkg.sv
// rtl/md5_uart_pkg.sv - shared types, characters and helpers for the MD5 result reporter
package md5_uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND,
      DONE
   } state_t;

   localparam logic [7:0] CHAR_F  = 8'h46;
   localparam logic [7:0] CHAR_N  = 8'h4E;
   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;

   localparam int FRAME_BYTES = 11;

   // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'
   function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
      if (nibble < 4'd10)
         return 8'h30 + {4'h0, nibble};
      else
         return 8'h37 + {4'h0, nibble};
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer; accepts the next byte in the cycle it reports done
module uart_tx_byte #(
   parameter int CLK_DIV = 868
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready,
   output logic       done
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic [7:0]    shift;
   logic          active;
   logic          baud_end;

   assign baud_end = (baud_cnt == CW'(CLK_DIV - 1));
   // done marks the last cycle of the stop bit so a chained start leaves no idle gap
   assign done     = active && baud_end && (bit_cnt == 4'd9);
   assign ready    = !active || done;

   always_ff @(posedge CLK) begin
      if (reset) begin
         active   <= 1'b0;
         tx       <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
      end else if (start && ready) begin
         active   <= 1'b1;
         tx       <= 1'b0;
         shift    <= data;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else if (active) begin
         if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
               active <= 1'b0;
               tx     <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'd8) begin
                  tx <= 1'b1;
               end else begin
                  tx    <= shift[0];
                  shift <= {1'b0, shift[7:1]};
               end
            end
         end else begin
            baud_cnt <= baud_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/md5_result_uart_tx.sv
// rtl/md5_result_uart_tx.sv - captures a finished MD5 search and reports it as "F/N<hex>\r\n"
module md5_result_uart_tx
   import md5_uart_pkg::*;
#(
   parameter int CLK_DIV = 868,
   parameter int NIBBLES = 8
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic                 status_done,
   input  logic                 status_found,
   input  logic [4*NIBBLES-1:0] target,
   output logic                 tx,
   output logic                 busy,
   output logic                 sent
);

   localparam logic [3:0] LAST = 4'(FRAME_BYTES - 1);

   state_t               state, state_nx;
   logic [3:0]           byte_idx;
   logic [4*NIBBLES-1:0] tgt_r;
   logic                 found_r;
   logic                 done_q;
   logic                 trigger;
   logic                 ser_start, ser_ready, ser_done;
   logic [7:0]           cur_byte;
   logic [3:0]           nib;
   int                   sel;

   assign busy    = (state == LOAD) || (state == SEND);
   assign sent    = (state == DONE);
   assign trigger = status_done && !done_q && !busy;

   // The next byte is handed over in the done cycle itself, so SEND looks one index ahead
   assign ser_start = ((state == LOAD) && ser_ready) ||
                      ((state == SEND) && ser_done && (byte_idx != LAST));

   always_comb begin
      sel      = int'(byte_idx) + ((state == SEND) ? 1 : 0);
      nib      = '0;
      cur_byte = CHAR_LF;
      if (sel == 0) begin
         cur_byte = found_r ? CHAR_F : CHAR_N;
      end else if (sel <= NIBBLES) begin
         nib      = 4'(tgt_r >> (4 * (NIBBLES - sel)));
         cur_byte = hex_ascii(nib);
      end else if (sel == NIBBLES + 1) begin
         cur_byte = CHAR_CR;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state    <= IDLE;
         done_q   <= 1'b1;
         byte_idx <= '0;
         tgt_r    <= '0;
         found_r  <= 1'b0;
      end else begin
         state  <= state_nx;
         done_q <= status_done;
         if (trigger) begin
            tgt_r    <= target;
            found_r  <= status_found;
            byte_idx <= '0;
         end else if ((state == SEND) && ser_done && (byte_idx != LAST)) begin
            byte_idx <= byte_idx + 4'd1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: state_nx = trigger ? LOAD : IDLE;
         LOAD:       if (ser_ready) state_nx = SEND;
         SEND:       if (ser_done && (byte_idx == LAST)) state_nx = DONE;
         default:    state_nx = IDLE;
      endcase
   end

   uart_tx_byte #(
      .CLK_DIV(CLK_DIV)
   ) u_ser (
      .CLK  (CLK),
      .reset(reset),
      .start(ser_start),
      .data (cur_byte),
      .tx   (tx),
      .ready(ser_ready),
      .done (ser_done)
   );

endmodule

// File: tb/tb_md5_result_uart_tx.sv
// tb/tb_md5_result_uart_tx.sv - scoreboard bench: two instances (CLK_DIV 4 and 2) decoded by monitors
module tb_md5_result_uart_tx;

   logic        CLK = 1'b0;
   logic        reset;
   logic [1:0]  sd;
   logic [1:0]  fnd;
   logic [31:0] tgt [2];
   wire  [1:0]  tx_w, busy_w, sent_w;

   int checks = 0;
   int errors = 0;
   int exp_frames [2];
   int sent_cnt [2];
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];

   always #5 CLK = ~CLK;

   md5_result_uart_tx #(.CLK_DIV(4), .NIBBLES(8)) u_dut4 (
      .CLK(CLK), .reset(reset), .status_done(sd[0]), .status_found(fnd[0]),
      .target(tgt[0]), .tx(tx_w[0]), .busy(busy_w[0]), .sent(sent_w[0])
   );

   md5_result_uart_tx #(.CLK_DIV(2), .NIBBLES(8)) u_dut2 (
      .CLK(CLK), .reset(reset), .status_done(sd[1]), .status_found(fnd[1]),
      .target(tgt[1]), .tx(tx_w[1]), .busy(busy_w[1]), .sent(sent_w[1])
   );

   always @(negedge CLK)
      for (int d = 0; d < 2; d++)
         if (sent_w[d]) sent_cnt[d]++;

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   task automatic push_b(input int d, input logic [7:0] v);
      if (d == 0) q0.push_back(v);
      else        q1.push_back(v);
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   task automatic pop_b(input int d, output logic [7:0] v);
      if (d == 0) v = q0.pop_front();
      else        v = q1.pop_front();
   endtask

   task automatic flush(input int d);
      if (d == 0) q0.delete();
      else        q1.delete();
   endtask

   // Reference: one ASCII report line built from the value, most significant digit first
   task automatic push_frame(input int d, input logic [31:0] t, input bit f);
      int n;
      push_b(d, f ? 8'h46 : 8'h4E);
      for (int i = 7; i >= 0; i--) begin
         n = (t / (32'd1 << (4 * i))) % 16;
         push_b(d, (n < 10) ? 8'(48 + n) : 8'(65 + n - 10));
      end
      push_b(d, 8'h0D);
      push_b(d, 8'h0A);
   endtask

   task automatic raise(input int d, input logic [31:0] t, input bit f);
      @(negedge CLK);
      tgt[d] = t;
      fnd[d] = f;
      sd[d]  = 1'b1;
      push_frame(d, t, f);
      exp_frames[d]++;
   endtask

   task automatic drop(input int d);
      @(negedge CLK);
      sd[d] = 1'b0;
   endtask

   task automatic wait_sent(input int d, input int budget);
      bit seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge CLK);
         if (sent_w[d]) seen = 1;
      end
      check_eq($sformatf("sent_within_budget_d%0d", d), seen, 1);
   endtask

   task automatic monitor(input int d, input int div);
      logic [7:0] got, req;
      bit ok, busy_ok, abort;
      forever begin
         @(negedge CLK);
         if (reset || tx_w[d]) continue;
         if (qsize(d) == 0) begin
            check_eq($sformatf("unexpected_frame_d%0d", d), tx_w[d], 1);
            while (!tx_w[d] && !reset) @(negedge CLK);
            continue;
         end
         abort   = 0;
         busy_ok = 1;
         got     = '0;
         for (int pos = 0; pos < 11 && !abort; pos++) begin
            ok = 1;
            for (int b = 0; b < 10 && !abort; b++) begin
               for (int c = 0; c < div && !abort; c++) begin
                  if (!(pos == 0 && b == 0 && c == 0)) @(negedge CLK);
                  if (reset) begin
                     abort = 1;
                  end else begin
                     if (!busy_w[d]) busy_ok = 0;
                     if (b == 0 && tx_w[d] !== 1'b0) ok = 0;
                     else if (b == 9 && tx_w[d] !== 1'b1) ok = 0;
                     else if (b >= 1 && b <= 8) begin
                        if (c == 0) got[b-1] = tx_w[d];
                        else if (tx_w[d] !== got[b-1]) ok = 0;
                     end
                  end
               end
            end
            if (!abort) begin
               pop_b(d, req);
               check_eq($sformatf("bit_framing_d%0d_byte%0d", d, pos), ok, 1);
               check_eq($sformatf("byte_d%0d_pos%0d", d, pos), got, req);
            end
         end
         if (abort) begin
            flush(d);
         end else begin
            @(negedge CLK);
            check_eq($sformatf("sent_after_stop_d%0d", d), sent_w[d], 1);
            check_eq($sformatf("busy_low_at_sent_d%0d", d), busy_w[d], 0);
            check_eq($sformatf("busy_through_frame_d%0d", d), busy_ok, 1);
         end
      end
   endtask

   initial begin
      bit quiet;
      reset = 1'b1;
      sd    = '0;
      fnd   = '0;
      tgt[0] = '0;
      tgt[1] = '0;
      exp_frames[0] = 0; exp_frames[1] = 0;
      sent_cnt[0]   = 0; sent_cnt[1]   = 0;
      fork
         monitor(0, 4);
         monitor(1, 2);
      join_none
      repeat (3) @(negedge CLK);
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("reset_tx_d%0d", d), tx_w[d], 1);
         check_eq($sformatf("reset_busy_d%0d", d), busy_w[d], 0);
         check_eq($sformatf("reset_sent_d%0d", d), sent_w[d], 0);
      end
      reset = 1'b0;
      repeat (2) @(negedge CLK);

      // Found result, with start-bit latency
      raise(0, 32'h1234ABCD, 1);
      @(negedge CLK);
      check_eq("latency_tx_high_after_trigger", tx_w[0], 1);
      check_eq("busy_after_trigger", busy_w[0], 1);
      @(negedge CLK);
      check_eq("latency_start_bit", tx_w[0], 0);
      wait_sent(0, 600);
      drop(0);

      raise(0, 32'h00000000, 0);
      wait_sent(0, 600);
      drop(0);

      // Inputs churn mid-frame; the captured values must be sent, and no second frame
      raise(0, $urandom, 1'($urandom_range(0, 1)));
      repeat (2 + 3 * 40) @(negedge CLK);
      tgt[0] = 32'hFFFFFFFF;
      fnd[0] = ~fnd[0];
      sd[0]  = 1'b0;
      repeat (3 * 40) @(negedge CLK);
      sd[0] = 1'b1;
      wait_sent(0, 600);
      quiet = 1;
      repeat (500) begin
         @(negedge CLK);
         if (busy_w[0] || !tx_w[0]) quiet = 0;
      end
      check_eq("no_requeued_frame", quiet, 1);
      drop(0);

      raise(0, 32'hDEADBEEF, 1);
      wait_sent(0, 600);
      drop(0);

      raise(1, 32'h0F0F0F0F, 0);
      wait_sent(1, 300);
      drop(1);

      for (int k = 0; k < 3; k++) begin
         raise(0, $urandom, 1'($urandom_range(0, 1)));
         raise(1, $urandom, 1'($urandom_range(0, 1)));
         wait_sent(1, 300);
         wait_sent(0, 600);
         drop(0);
         drop(1);
         repeat ($urandom_range(1, 5)) @(negedge CLK);
      end

      // Reset mid-frame with status_done held high across release
      raise(0, $urandom, 1);
      repeat (50) @(negedge CLK);
      reset = 1'b1;
      exp_frames[0]--;
      @(negedge CLK);
      check_eq("reset_midframe_tx", tx_w[0], 1);
      check_eq("reset_midframe_busy", busy_w[0], 0);
      check_eq("reset_midframe_sent", sent_w[0], 0);
      repeat (2) @(negedge CLK);
      reset = 1'b0;
      quiet = 1;
      repeat (100) begin
         @(negedge CLK);
         if (busy_w[0] || !tx_w[0] || sent_w[0]) quiet = 0;
      end
      check_eq("no_frame_after_reset_release", quiet, 1);
      drop(0);
      repeat (5) @(negedge CLK);

      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("sent_count_d%0d", d), sent_cnt[d], exp_frames[d]);
         check_eq($sformatf("scoreboard_empty_d%0d", d), qsize(d), 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
